// File: rtl/decode_stage_buffered.sv
// decode_stage_buffered
//   RV32I decode stage with a DEPTH-entry input queue between fetch and the
//   ALU/issue stage. Raw instruction words and their PCs are queued; the head
//   entry is decoded combinationally, so a word pushed into an empty queue is
//   presented one cycle later.
//
// Ports
//   clock        sole clock, rising edge
//   reset_c      synchronous active-high reset (wins over flush/push/pop)
//   flush        empties the queue; same-cycle push/pop are discarded
//   fetch_*      upstream valid/ready handshake, instruction word and PC
//   dec_*        downstream valid/ready handshake and decoded head fields
//   occupancy    number of entries currently held
module decode_stage_buffered #(
    parameter int XLEN  = 32,
    parameter int PC_W  = 32,
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset_c,
    input  logic             flush,
    input  logic             fetch_valid,
    output logic             fetch_ready,
    input  logic [31:0]      fetch_instr,
    input  logic [PC_W-1:0]  fetch_pc,
    output logic             dec_valid,
    input  logic             dec_ready,
    output logic [PC_W-1:0]  dec_pc,
    output logic [6:0]       dec_opcode,
    output logic [4:0]       dec_rd,
    output logic [4:0]       dec_rs1,
    output logic [4:0]       dec_rs2,
    output logic [2:0]       dec_funct3,
    output logic [6:0]       dec_funct7,
    output logic [XLEN-1:0]  dec_imm,
    output logic [2:0]       dec_fmt,
    output logic             dec_illegal,
    output logic [CNT_W-1:0] occupancy
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    typedef enum logic [2:0] {
        FMT_R   = 3'd0,
        FMT_I   = 3'd1,
        FMT_S   = 3'd2,
        FMT_B   = 3'd3,
        FMT_U   = 3'd4,
        FMT_J   = 3'd5,
        FMT_ILL = 3'd7
    } fmt_e;

    // ------------------------------------------------------------------
    // Queue storage and control
    // ------------------------------------------------------------------
    logic [31:0]      instr_mem [DEPTH];
    logic [PC_W-1:0]  pc_mem    [DEPTH];

    logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CNT_W-1:0] count_reg;
    logic             push, pop;
    logic [DEPTH-1:0] wr_en;

    // Ready depends only on stored occupancy, never on dec_ready, so a pop
    // frees a slot for the following cycle only.
    assign fetch_ready = (count_reg < FULL_CNT);
    assign dec_valid   = (count_reg != '0);
    assign occupancy   = count_reg;

    assign push = fetch_valid && fetch_ready;
    assign pop  = dec_valid && dec_ready;

    // Indices wrap explicitly so DEPTH need not be a power of two.
    assign wr_ptr_next = (wr_ptr_reg == LAST_PTR) ? '0 : wr_ptr_reg + PTR_W'(1);
    assign rd_ptr_next = (rd_ptr_reg == LAST_PTR) ? '0 : rd_ptr_reg + PTR_W'(1);

    // Writing an entry during flush/reset is harmless: the pointers and count
    // are cleared, so the word is never presented.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_en
        assign wr_en[gi] = push && (wr_ptr_reg == PTR_W'(gi));
    end

    always_ff @(posedge clock) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (wr_en[i]) begin
                instr_mem[i] <= fetch_instr;
                pc_mem[i]    <= fetch_pc;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset_c || flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_next;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_next;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Head decode (combinational from stored raw bits)
    // ------------------------------------------------------------------
    logic [31:0]        head_instr;
    fmt_e               fmt;
    logic signed [31:0] imm32;

    assign head_instr = instr_mem[rd_ptr_reg];
    assign dec_pc     = pc_mem[rd_ptr_reg];
    assign dec_opcode = head_instr[6:0];

    always_comb begin
        fmt   = FMT_ILL;
        imm32 = '0;
        case (head_instr[6:0])
            7'b0110011: fmt = FMT_R;
            7'b0010011, 7'b0000011, 7'b1100111,
            7'b1110011, 7'b0001111: begin
                fmt   = FMT_I;
                imm32 = {{20{head_instr[31]}}, head_instr[31:20]};
            end
            7'b0100011: begin
                fmt   = FMT_S;
                imm32 = {{20{head_instr[31]}}, head_instr[31:25], head_instr[11:7]};
            end
            7'b1100011: begin
                fmt   = FMT_B;
                imm32 = {{20{head_instr[31]}}, head_instr[7], head_instr[30:25],
                         head_instr[11:8], 1'b0};
            end
            7'b0110111, 7'b0010111: begin
                fmt   = FMT_U;
                imm32 = {head_instr[31:12], 12'b0};
            end
            7'b1101111: begin
                fmt   = FMT_J;
                imm32 = {{12{head_instr[31]}}, head_instr[19:12], head_instr[20],
                         head_instr[30:21], 1'b0};
            end
            default: begin
                fmt   = FMT_ILL;
                imm32 = '0;
            end
        endcase
    end

    assign dec_fmt     = fmt;
    // Every legal opcode already ends in 2'b11; the explicit test keeps the
    // compressed-encoding rule visible.
    assign dec_illegal = (fmt == FMT_ILL) || (head_instr[1:0] != 2'b11);
    assign dec_imm     = XLEN'(imm32);

    // Fields a format does not encode are zeroed so consumers can use them
    // without re-checking the format.
    assign dec_rd     = (fmt == FMT_S || fmt == FMT_B) ? 5'd0 : head_instr[11:7];
    assign dec_rs1    = (fmt == FMT_U || fmt == FMT_J) ? 5'd0 : head_instr[19:15];
    assign dec_rs2    = (fmt == FMT_R || fmt == FMT_S || fmt == FMT_B) ? head_instr[24:20] : 5'd0;
    assign dec_funct3 = (fmt == FMT_U || fmt == FMT_J) ? 3'd0 : head_instr[14:12];
    assign dec_funct7 = (fmt == FMT_R) ? head_instr[31:25] : 7'd0;

endmodule

// File: tb/tb_decode_stage_buffered.sv
// tb_decode_stage_buffered
//   Table of instruction words with hand-derived decode results, streamed
//   through the queue. Accepted pushes go into a scoreboard queue; every pop
//   is compared against the scoreboard head. Queue occupancy/handshake state
//   is compared against the scoreboard size every cycle.
module tb_decode_stage_buffered;

    localparam int XLEN  = 32;
    localparam int PC_W  = 32;
    localparam int DEPTH = 2;
    localparam int CNT_W = 2;
    localparam int NVEC  = 16;

    logic             clock = 1'b0;
    logic             reset_c, flush, fetch_valid, fetch_ready, dec_valid, dec_ready;
    logic [31:0]      fetch_instr;
    logic [PC_W-1:0]  fetch_pc, dec_pc;
    logic [6:0]       dec_opcode, dec_funct7;
    logic [4:0]       dec_rd, dec_rs1, dec_rs2;
    logic [2:0]       dec_funct3, dec_fmt;
    logic [XLEN-1:0]  dec_imm;
    logic             dec_illegal;
    logic [CNT_W-1:0] occupancy;

    decode_stage_buffered #(.XLEN(XLEN), .PC_W(PC_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clock(clock), .reset_c(reset_c), .flush(flush),
        .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
        .fetch_instr(fetch_instr), .fetch_pc(fetch_pc),
        .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_pc(dec_pc),
        .dec_opcode(dec_opcode), .dec_rd(dec_rd), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
        .dec_funct3(dec_funct3), .dec_funct7(dec_funct7), .dec_imm(dec_imm),
        .dec_fmt(dec_fmt), .dec_illegal(dec_illegal), .occupancy(occupancy)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [2:0]  fmt;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic        ill;
    } dec_t;

    typedef struct {
        logic [31:0] instr;
        dec_t        exp;
    } vec_t;

    typedef struct {
        dec_t        d;
        logic [6:0]  op;
        logic [31:0] pc;
    } sb_t;

    vec_t        vecs [NVEC];
    sb_t         sb [$];
    int          checks = 0;
    int          errors = 0;
    logic        chk_en = 1'b0;
    logic        acc;
    logic [31:0] pc_next = 32'h0000_1000;

    function automatic vec_t mk(input logic [31:0] instr, input logic [2:0] fmt,
                                input logic [4:0] rd, input logic [4:0] rs1,
                                input logic [4:0] rs2, input logic [2:0] f3,
                                input logic [6:0] f7, input logic [31:0] imm,
                                input logic ill);
        vec_t v;
        v.instr = instr;
        v.exp   = '{fmt: fmt, rd: rd, rs1: rs1, rs2: rs2, f3: f3, f7: f7, imm: imm, ill: ill};
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One clock cycle: drive inputs, let them settle, check state against the
    // model, account for handshakes, then advance past the rising edge.
    task automatic step(input logic fv, input int idx, input logic dr,
                        input logic fl, input logic rs, output logic accepted);
        sb_t  e;
        dec_t act;
        fetch_valid = fv;
        fetch_instr = vecs[idx].instr;
        fetch_pc    = pc_next;
        dec_ready   = dr;
        flush       = fl;
        reset_c     = rs;
        #1;
        accepted = fv && fetch_ready;
        if (chk_en) begin
            checks++;
            if (occupancy !== CNT_W'(sb.size()) || dec_valid !== (sb.size() != 0) ||
                fetch_ready !== (sb.size() < DEPTH)) begin
                errors++;
                $display("FAIL state: got occ=%0d valid=%b ready=%b, expected occ=%0d valid=%b ready=%b",
                         occupancy, dec_valid, fetch_ready, sb.size(), sb.size() != 0, sb.size() < DEPTH);
            end
        end
        if (rs || fl) begin
            sb.delete();
        end else begin
            if (dec_valid && dec_ready) begin
                checks++;
                act = '{fmt: dec_fmt, rd: dec_rd, rs1: dec_rs1, rs2: dec_rs2, f3: dec_funct3,
                        f7: dec_funct7, imm: dec_imm, ill: dec_illegal};
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL pop_empty: got pop of pc=%h, expected no valid output", dec_pc);
                end else begin
                    e = sb.pop_front();
                    $display("pop  pc=%h op=%h fmt=%0d rd=%0d rs1=%0d rs2=%0d f3=%0d f7=%h imm=%h ill=%b",
                             dec_pc, dec_opcode, dec_fmt, dec_rd, dec_rs1, dec_rs2,
                             dec_funct3, dec_funct7, dec_imm, dec_illegal);
                    if (act !== e.d || dec_pc !== e.pc || dec_opcode !== e.op) begin
                        errors++;
                        $display("FAIL decode: got pc=%h op=%h fields=%h, expected pc=%h op=%h fields=%h",
                                 dec_pc, dec_opcode, act, e.pc, e.op, e.d);
                    end
                end
            end
            if (accepted) begin
                sb.push_back('{d: vecs[idx].exp, op: vecs[idx].instr[6:0], pc: pc_next});
                pc_next = pc_next + 32'd4;
            end
        end
        @(negedge clock);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        //              instr          fmt  rd    rs1   rs2   f3    f7      imm           ill
        vecs[0]  = mk(32'hFFF00093, 3'd1, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFFFFFF, 1'b0); // addi x1,x0,-1
        vecs[1]  = mk(32'h0020A423, 3'd2, 5'd0, 5'd1, 5'd2, 3'd2, 7'h00, 32'h00000008, 1'b0); // sw x2,8(x1)
        vecs[2]  = mk(32'hFE000EE3, 3'd3, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFFFFFC, 1'b0); // beq -4
        vecs[3]  = mk(32'h123452B7, 3'd4, 5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 32'h12345000, 1'b0); // lui x5
        vecs[4]  = mk(32'h00000000, 3'd7, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'h00000000, 1'b1); // all zero
        vecs[5]  = mk(32'h00000013, 3'd1, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'h00000000, 1'b0); // nop
        vecs[6]  = mk(32'h402081B3, 3'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'h00000000, 1'b0); // sub x3,x1,x2
        vecs[7]  = mk(32'h008000EF, 3'd5, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'h00000008, 1'b0); // jal x1,8
        vecs[8]  = mk(32'hFFDFF06F, 3'd5, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFFFFFC, 1'b0); // jal x0,-4
        vecs[9]  = mk(32'h00001517, 3'd4, 5'd10, 5'd0, 5'd0, 3'd0, 7'h00, 32'h00001000, 1'b0); // auipc x10,1
        vecs[10] = mk(32'hFF812303, 3'd1, 5'd6, 5'd2, 5'd0, 3'd2, 7'h00, 32'hFFFFFFF8, 1'b0); // lw x6,-8(x2)
        vecs[11] = mk(32'h00209863, 3'd3, 5'd0, 5'd1, 5'd2, 3'd1, 7'h00, 32'h00000010, 1'b0); // bne +16
        vecs[12] = mk(32'hFE532E23, 3'd2, 5'd0, 5'd6, 5'd5, 3'd2, 7'h00, 32'hFFFFFFFC, 1'b0); // sw x5,-4(x6)
        vecs[13] = mk(32'h00000012, 3'd7, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'h00000000, 1'b1); // low bits 10
        vecs[14] = mk(32'h0000007F, 3'd7, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'h00000000, 1'b1); // unknown op
        vecs[15] = mk(32'h00008067, 3'd1, 5'd0, 5'd1, 5'd0, 3'd0, 7'h00, 32'h00000000, 1'b0); // jalr x0,0(x1)

        fetch_valid = 1'b0; fetch_instr = '0; fetch_pc = '0;
        dec_ready = 1'b0; flush = 1'b0; reset_c = 1'b1;

        // Reset
        step(1'b0, 0, 1'b0, 1'b0, 1'b1, acc);
        step(1'b0, 0, 1'b0, 1'b0, 1'b1, acc);
        check("rst_occupancy", 64'(occupancy), 64'd0);
        check("rst_dec_valid", 64'(dec_valid), 64'd0);
        check("rst_fetch_ready", 64'(fetch_ready), 64'd1);
        chk_en = 1'b1;

        // Table: stream every vector with the consumer always ready
        for (int i = 0; i < NVEC; i++) begin
            n = 0;
            do begin
                step(1'b1, i, 1'b1, 1'b0, 1'b0, acc);
                n++;
            end while (!acc && n < 10);
            check("table_push_accepted", 64'(acc), 64'd1);
        end
        step(1'b0, 0, 1'b1, 1'b0, 1'b0, acc);
        step(1'b0, 0, 1'b1, 1'b0, 1'b0, acc);
        check("table_drained", 64'(sb.size()), 64'd0);

        // Full queue back-pressure: A,B accepted, C held until a slot frees
        step(1'b1, 0, 1'b0, 1'b0, 1'b0, acc);
        check("full_push_a", 64'(acc), 64'd1);
        step(1'b1, 1, 1'b0, 1'b0, 1'b0, acc);
        check("full_push_b", 64'(acc), 64'd1);
        step(1'b1, 2, 1'b0, 1'b0, 1'b0, acc);
        check("full_c_held", 64'(acc), 64'd0);
        step(1'b1, 2, 1'b1, 1'b0, 1'b0, acc);
        check("full_pop_cycle_no_push", 64'(acc), 64'd0);
        step(1'b1, 2, 1'b1, 1'b0, 1'b0, acc);
        check("full_c_accepted_next", 64'(acc), 64'd1);
        for (int i = 0; i < 3; i++) step(1'b0, 0, 1'b1, 1'b0, 1'b0, acc);
        check("full_order_drained", 64'(sb.size()), 64'd0);

        // Flush while full with a push offered
        step(1'b1, 3, 1'b0, 1'b0, 1'b0, acc);
        step(1'b1, 4, 1'b0, 1'b0, 1'b0, acc);
        check("flush_prefill", 64'(occupancy), 64'd2);
        step(1'b1, 5, 1'b0, 1'b1, 1'b0, acc);
        check("flush_full_occupancy", 64'(occupancy), 64'd0);
        check("flush_full_valid", 64'(dec_valid), 64'd0);
        // Flush with a push and a pop both possible: both discarded
        step(1'b1, 6, 1'b0, 1'b0, 1'b0, acc);
        step(1'b1, 7, 1'b1, 1'b1, 1'b0, acc);
        check("flush_push_dropped", 64'(occupancy), 64'd0);
        step(1'b1, 8, 1'b1, 1'b0, 1'b0, acc);
        step(1'b0, 0, 1'b1, 1'b0, 1'b0, acc);
        check("flush_after_push_pop", 64'(sb.size()), 64'd0);

        // Reset while full with the consumer ready: no pop, queue empty
        step(1'b1, 9, 1'b0, 1'b0, 1'b0, acc);
        step(1'b1, 10, 1'b0, 1'b0, 1'b0, acc);
        step(1'b1, 11, 1'b1, 1'b0, 1'b1, acc);
        check("reset_full_occupancy", 64'(occupancy), 64'd0);
        check("reset_full_ready", 64'(fetch_ready), 64'd1);

        // Random traffic exercises pointer wrap with mixed push/pop/flush
        for (int c = 0; c < 400; c++) begin
            step(($urandom % 4) != 0, int'($urandom_range(NVEC - 1, 0)), ($urandom % 3) != 0,
                 ($urandom % 40) == 0, ($urandom % 97) == 0, acc);
        end
        for (int c = 0; c < 10 && sb.size() != 0; c++) step(1'b0, 0, 1'b1, 1'b0, 1'b0, acc);
        check("final_drained", 64'(sb.size()), 64'd0);
        check("final_occupancy", 64'(occupancy), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
